// File: rtl/cordic_rr_scheduler.sv
// cordic_rr_scheduler
//   Two requesters share one fixed-latency pipelined CORDIC vectoring core.
//   A round-robin arbiter issues at most one job per cycle. A tag delay line
//   remembers which requester owns each in-flight result, and the result is
//   steered into that requester's response FIFO. Per-requester credits make
//   sure a response FIFO is never pushed while full.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ena                        issue enable (gates new grants only)
//   reqN_valid/ready/x/y       job input port of requester N (N = 0, 1)
//   core_x, core_y             registered operands into the core
//   core_mag, core_phase       core results, valid PIPE_LAT cycles after issue
//   rspN_valid/ready/mag/phase response FIFO head of requester N
//   busy                       any tag in flight or any FIFO non-empty
module cordic_rr_scheduler #(
  parameter int WIDTH     = 16,
  parameter int PIPE_LAT  = 16,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic [WIDTH-1:0] core_x,
  output logic [WIDTH-1:0] core_y,
  input  logic [WIDTH-1:0] core_mag,
  input  logic [31:0]      core_phase,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_mag,
  output logic [31:0]      rsp0_phase,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_mag,
  output logic [31:0]      rsp1_phase,
  output logic             busy
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  logic [1:0]       req_valid_w;
  logic [1:0]       rsp_ready_w;
  logic [WIDTH-1:0] req_x_w [2];
  logic [WIDTH-1:0] req_y_w [2];

  assign req_valid_w = {req1_valid, req0_valid};
  assign rsp_ready_w = {rsp1_ready, rsp0_ready};
  assign req_x_w[0]  = req0_x;
  assign req_x_w[1]  = req1_x;
  assign req_y_w[0]  = req0_y;
  assign req_y_w[1]  = req1_y;

  // last_q = requester granted most recently; reset value 1 makes requester 0
  // win the first contended cycle.
  logic             last_q, last_d;
  logic [1:0]       elig, grant;
  logic [CW-1:0]    cred_q [2];
  logic [CW-1:0]    cred_d [2];
  logic [WIDTH-1:0] core_x_q, core_x_d, core_y_q, core_y_d;

  // Stage k holds the tag of the job issued k+1 edges ago; stage PIPE_LAT
  // lines up with the core output of that job.
  logic [PIPE_LAT:0] tag_v_q, tag_id_q;

  logic [1:0]       push, pop;
  logic [CW-1:0]    cnt_q [2];
  logic [CW-1:0]    cnt_d [2];
  logic [PW-1:0]    wr_q [2];
  logic [PW-1:0]    wr_d [2];
  logic [PW-1:0]    rd_q [2];
  logic [PW-1:0]    rd_d [2];
  logic [WIDTH-1:0] mem_mag [2][OUT_DEPTH];
  logic [31:0]      mem_ph  [2][OUT_DEPTH];
  logic [WIDTH-1:0] head_mag [2];
  logic [31:0]      head_ph  [2];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(OUT_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Arbitration and issue
  always_comb begin
    elig     = '0;
    grant    = '0;
    last_d   = last_q;
    core_x_d = core_x_q;
    core_y_d = core_y_q;
    for (int r = 0; r < 2; r++) begin
      elig[r] = req_valid_w[r] && (cred_q[r] != '0) && ena;
    end
    if (elig == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end else begin
      grant = elig;
    end
    if (grant[0]) begin
      last_d   = 1'b0;
      core_x_d = req_x_w[0];
      core_y_d = req_y_w[0];
    end else if (grant[1]) begin
      last_d   = 1'b1;
      core_x_d = req_x_w[1];
      core_y_d = req_y_w[1];
    end
  end

  // FIFO and credit bookkeeping
  always_comb begin
    push = '0;
    pop  = '0;
    for (int r = 0; r < 2; r++) begin
      push[r]  = tag_v_q[PIPE_LAT] && (tag_id_q[PIPE_LAT] == 1'(r));
      pop[r]   = (cnt_q[r] != '0) && rsp_ready_w[r];
      cnt_d[r] = cnt_q[r];
      cred_d[r] = cred_q[r];
      wr_d[r]  = push[r] ? ptr_inc(wr_q[r]) : wr_q[r];
      rd_d[r]  = pop[r]  ? ptr_inc(rd_q[r]) : rd_q[r];
      case ({push[r], pop[r]})
        2'b10:   cnt_d[r] = cnt_q[r] + 1'b1;
        2'b01:   cnt_d[r] = cnt_q[r] - 1'b1;
        default: cnt_d[r] = cnt_q[r];
      endcase
      // A grant and a pop on the same edge cancel out.
      case ({grant[r], pop[r]})
        2'b10:   cred_d[r] = cred_q[r] - 1'b1;
        2'b01:   cred_d[r] = cred_q[r] + 1'b1;
        default: cred_d[r] = cred_q[r];
      endcase
      head_mag[r] = (cnt_q[r] != '0) ? mem_mag[r][rd_q[r]] : '0;
      head_ph[r]  = (cnt_q[r] != '0) ? mem_ph[r][rd_q[r]]  : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      core_x_q <= '0;
      core_y_q <= '0;
      tag_v_q  <= '0;
      tag_id_q <= '0;
      for (int r = 0; r < 2; r++) begin
        cred_q[r] <= CW'(OUT_DEPTH);
        cnt_q[r]  <= '0;
        wr_q[r]   <= '0;
        rd_q[r]   <= '0;
      end
    end else begin
      last_q   <= last_d;
      core_x_q <= core_x_d;
      core_y_q <= core_y_d;
      // The core has no enable, so the tag line shifts every cycle.
      tag_v_q  <= {tag_v_q[PIPE_LAT-1:0], |grant};
      tag_id_q <= {tag_id_q[PIPE_LAT-1:0], grant[1]};
      for (int r = 0; r < 2; r++) begin
        cred_q[r] <= cred_d[r];
        cnt_q[r]  <= cnt_d[r];
        wr_q[r]   <= wr_d[r];
        rd_q[r]   <= rd_d[r];
      end
    end
  end

  // Storage needs no reset: the read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) begin
        mem_mag[r][wr_q[r]] <= core_mag;
        mem_ph[r][wr_q[r]]  <= core_phase;
      end
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign core_x     = core_x_q;
  assign core_y     = core_y_q;
  assign rsp0_valid = (cnt_q[0] != '0);
  assign rsp1_valid = (cnt_q[1] != '0);
  assign rsp0_mag   = head_mag[0];
  assign rsp0_phase = head_ph[0];
  assign rsp1_mag   = head_mag[1];
  assign rsp1_phase = head_ph[1];
  assign busy       = (|tag_v_q) || rsp0_valid || rsp1_valid;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
module tb_cordic_rr_scheduler;
  localparam int WIDTH = 16;
  localparam int PL    = 16;
  localparam int OD    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic [WIDTH-1:0] core_x, core_y, core_mag;
  logic [31:0] core_phase;
  logic rsp0_valid, rsp1_valid;
  logic rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [WIDTH-1:0] rsp0_mag, rsp1_mag;
  logic [31:0] rsp0_phase, rsp1_phase;
  logic busy;

  cordic_rr_scheduler #(.WIDTH(WIDTH), .PIPE_LAT(PL), .OUT_DEPTH(OD)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .core_x(core_x), .core_y(core_y), .core_mag(core_mag), .core_phase(core_phase),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_mag(rsp0_mag), .rsp0_phase(rsp0_phase),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_mag(rsp1_mag), .rsp1_phase(rsp1_phase),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stub core: PL-deep delay, mag = x, phase = {y, x}.
  logic [WIDTH-1:0] dx [PL];
  logic [WIDTH-1:0] dy [PL];
  always @(posedge clk) begin
    dx[0] <= core_x;
    dy[0] <= core_y;
    for (int i = 1; i < PL; i++) begin
      dx[i] <= dx[i-1];
      dy[i] <= dy[i-1];
    end
  end
  assign core_mag   = dx[PL-1];
  assign core_phase = {dy[PL-1], dx[PL-1]};

  typedef struct { logic [WIDTH-1:0] x; logic [WIDTH-1:0] y; } job_t;
  typedef struct { logic [WIDTH-1:0] mag; logic [31:0] ph; int t; } exp_t;

  job_t jobs [2][$];
  exp_t sb   [2][$];
  int   gseq [$];
  int   acc_cnt [2];
  logic acc [2];
  int   rmode [2];
  logic ena_rand = 1'b0;
  logic vrand = 1'b0;
  logic last_m = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Driver: updates inputs 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic [1:0] vv;
    #1;
    for (int r = 0; r < 2; r++) begin
      if (acc[r]) begin
        if (jobs[r].size() > 0) jobs[r].delete(0);
        acc[r] = 1'b0;
      end
    end
    if (ena_rand) ena = ($urandom_range(0, 7) != 0);
    rsp0_ready = (rmode[0] == 1) || (rmode[0] == 2 && $urandom_range(0, 2) != 0);
    rsp1_ready = (rmode[1] == 1) || (rmode[1] == 2 && $urandom_range(0, 2) != 0);
    for (int r = 0; r < 2; r++) begin
      vv[r] = (jobs[r].size() > 0) && (!vrand || $urandom_range(0, 3) != 0);
    end
    req0_valid = vv[0];
    req1_valid = vv[1];
    if (jobs[0].size() > 0) begin req0_x = jobs[0][0].x; req0_y = jobs[0][0].y; end
    if (jobs[1].size() > 0) begin req1_x = jobs[1][0].x; req1_y = jobs[1][0].y; end
  end

  // Monitor/scoreboard: reference model = per-requester list of accepted,
  // unpopped jobs with the cycle their result becomes visible.
  always @(negedge clk) begin
    logic [1:0] ev, el, eg, vin, rr, rdy, rv;
    logic [WIDTH-1:0] mg [2];
    logic [31:0] ph [2];
    if (!rst_n) begin
      chk("rst_rsp0_valid", 64'(rsp0_valid), 0);
      chk("rst_rsp1_valid", 64'(rsp1_valid), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_rsp0_mag", 64'(rsp0_mag), 0);
      chk("rst_rsp1_phase", 64'(rsp1_phase), 0);
      sb[0].delete();
      sb[1].delete();
      last_m = 1'b1;
      acc[0] = 1'b0;
      acc[1] = 1'b0;
    end else begin
      vin = {req1_valid, req0_valid};
      rr  = {rsp1_ready, rsp0_ready};
      rdy = {req1_ready, req0_ready};
      rv  = {rsp1_valid, rsp0_valid};
      mg[0] = rsp0_mag;   mg[1] = rsp1_mag;
      ph[0] = rsp0_phase; ph[1] = rsp1_phase;
      for (int r = 0; r < 2; r++) begin
        ev[r] = (sb[r].size() > 0) && (sb[r][0].t <= cyc);
        chk($sformatf("rsp%0d_valid", r), 64'(rv[r]), 64'(ev[r]));
        if (ev[r]) begin
          chk($sformatf("rsp%0d_mag", r), 64'(mg[r]), 64'(sb[r][0].mag));
          chk($sformatf("rsp%0d_phase", r), 64'(ph[r]), 64'(sb[r][0].ph));
        end else begin
          chk($sformatf("rsp%0d_empty_data", r), {16'(mg[r]), ph[r]}, 0);
        end
        el[r] = vin[r] && (OD - sb[r].size() > 0) && ena;
      end
      chk("busy", 64'(busy), 64'((sb[0].size() + sb[1].size()) > 0));
      if (el == 2'b11) eg = last_m ? 2'b01 : 2'b10;
      else             eg = el;
      chk("req0_ready", 64'(rdy[0]), 64'(eg[0]));
      chk("req1_ready", 64'(rdy[1]), 64'(eg[1]));
      for (int r = 0; r < 2; r++) begin
        if (ev[r] && rr[r]) sb[r].delete(0);
        if (rdy[r] && vin[r]) begin
          exp_t e;
          e.mag = (r == 0) ? req0_x : req1_x;
          e.ph  = (r == 0) ? {req0_y, req0_x} : {req1_y, req1_x};
          e.t   = cyc + PL + 2;
          sb[r].push_back(e);
          acc[r] = 1'b1;
          acc_cnt[r]++;
          gseq.push_back(r);
          last_m = 1'(r);
        end
        chk($sformatf("credit_bound%0d", r), 64'(sb[r].size() <= OD), 1);
      end
    end
  end

  task automatic add_job(input int r, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    job_t j;
    j.x = x;
    j.y = y;
    jobs[r].push_back(j);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while ((jobs[0].size() + jobs[1].size() + sb[0].size() + sb[1].size()) > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain_timeout"}, 64'(n >= budget), 0);
  endtask

  task automatic wait_acc(input string nm, input int target, input int budget);
    int n = 0;
    while ((acc_cnt[0] + acc_cnt[1]) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_accept_timeout"}, 64'(n >= budget), 0);
  endtask

  initial begin
    int n;
    acc[0] = 1'b0; acc[1] = 1'b0;
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    rmode[0] = 1; rmode[1] = 1;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_core_x", 64'(core_x), 0);
    chk("rst_core_y", 64'(core_y), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    ena = 1'b1;

    // Single job accepted on edge 10; result visible after edge 27.
    while (cyc < 8) @(negedge clk);
    add_job(0, 16'h1234, 16'h0056);
    n = 0;
    while (!rsp0_valid && n < 60) begin @(negedge clk); n++; end
    chk("single_latency", 64'(cyc), 27);
    chk("single_mag", 64'(rsp0_mag), 64'h1234);
    chk("single_phase", 64'(rsp0_phase), 64'h0056_1234);
    wait_idle("single", 100);
    chk("single_busy_after_pop", 64'(busy), 0);

    // Contention: both requesters continuously valid.
    gseq.delete();
    for (int i = 0; i < 4; i++) begin
      add_job(0, 16'h0100 + 16'(i), 16'h0A00 + 16'(i));
      add_job(1, 16'h0200 + 16'(i), 16'h0B00 + 16'(i));
    end
    wait_idle("contention", 300);
    chk("contention_grants", 64'(gseq.size()), 8);
    for (int i = 1; i < gseq.size(); i++) begin
      chk($sformatf("contention_alt%0d", i), 64'(gseq[i] != gseq[i-1]), 1);
    end

    // Backpressure on requester 1: only OD jobs get in while nobody pops.
    rmode[1] = 0;
    acc_cnt[1] = 0;
    for (int i = 0; i < 5; i++) add_job(1, 16'h0300 + 16'(i), 16'h0C00 + 16'(i));
    repeat (40) @(negedge clk);
    chk("bp_accepted", 64'(acc_cnt[1]), OD);
    chk("bp_rsp1_valid", 64'(rsp1_valid), 1);
    rmode[1] = 1;
    wait_idle("bp", 300);
    chk("bp_total", 64'(acc_cnt[1]), 5);

    // ena low while jobs are in flight.
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    add_job(0, 16'h0401, 16'h0D01);
    add_job(0, 16'h0402, 16'h0D02);
    add_job(1, 16'h0501, 16'h0E01);
    wait_acc("ena", 3, 30);
    @(posedge clk); #2;
    ena = 1'b0;
    add_job(0, 16'h0403, 16'h0D03);
    add_job(1, 16'h0502, 16'h0E02);
    repeat (5) @(posedge clk);
    #2;
    chk("ena_no_grant", 64'(acc_cnt[0] + acc_cnt[1]), 3);
    ena = 1'b1;
    wait_idle("ena", 300);

    // Reset mid-operation.
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    add_job(0, 16'h0601, 16'h0F01);
    add_job(0, 16'h0602, 16'h0F02);
    wait_acc("rst", 2, 30);
    repeat (8) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp0_valid", 64'(rsp0_valid), 0);
    chk("midrst_busy", 64'(busy), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 0);

    // Randomised traffic.
    ena_rand = 1'b1;
    vrand = 1'b1;
    rmode[0] = 2; rmode[1] = 2;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        int r;
        r = int'($urandom_range(0, 1));
        if (jobs[r].size() < 4) add_job(r, 16'($urandom), 16'($urandom));
      end
    end
    ena_rand = 1'b0;
    vrand = 1'b0;
    ena = 1'b1;
    rmode[0] = 1; rmode[1] = 1;
    wait_idle("random", 500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
